// File: rtl/icache_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : icache_fetch_ctrl
// Description : Multi-thread instruction-fetch controller for a direct-mapped,
//               one-word-per-line instruction cache with single-word refill.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_fetch_ctrl #(
    parameter int NTHREADS = 4,
    parameter int LINES    = 128
) (
    input  logic                    clk,
    input  logic                    nReset,
    input  logic [NTHREADS-1:0]     FetchReq,
    input  logic [32*NTHREADS-1:0]  FetchPC,
    input  logic                    Flush,
    output logic [NTHREADS-1:0]     FetchGrant,
    output logic [NTHREADS-1:0]     InstValid,
    output logic                    Enable,
    output logic [6:0]              CacheIndexRead,
    output logic                    WriteInst,
    output logic [6:0]              CacheIndexWrite,
    output logic [31:0]             InstData,
    output logic                    MemReq,
    output logic [31:0]             MemAddr,
    input  logic                    MemAck,
    input  logic [31:0]             MemData,
    output logic                    Busy
);

    localparam int c_IDX_W = 7;
    localparam int c_TAG_W = 32 - c_IDX_W - 2;
    localparam int c_TW    = (NTHREADS > 1) ? $clog2(NTHREADS) : 1;
    localparam logic [NTHREADS-1:0] c_ONE = NTHREADS'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_RESP   = 3'd2,
        S_MISS   = 3'd3,
        S_FILL   = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [c_TW-1:0]      r_thread;
    logic [c_TW-1:0]      r_last;
    logic [31:0]          r_pc;
    logic [31:0]          r_data;
    logic [LINES-1:0]     r_valid;
    logic [c_TAG_W-1:0]   r_tag [LINES];

    logic                 w_found;
    logic [c_TW-1:0]      w_gidx;
    logic [c_TW-1:0]      w_cand;
    logic [31:0]          w_sel_pc;
    logic [c_IDX_W-1:0]   w_idx;
    logic [c_TAG_W-1:0]   w_tag;
    logic                 w_hit;
    logic                 w_unused;

    assign w_idx    = r_pc[8:2];
    assign w_tag    = r_pc[31:9];
    assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign Busy     = (r_state != S_IDLE);
    assign w_unused = ^r_pc[1:0];

    // Round-robin search starting one past the last granted thread.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_cand  = '0;
        for (int i = 1; i <= NTHREADS; i++) begin
            w_cand = c_TW'((int'(r_last) + i) % NTHREADS);
            if (!w_found && FetchReq[w_cand]) begin
                w_found = 1'b1;
                w_gidx  = w_cand;
            end
        end
    end

    always_comb begin
        w_sel_pc = '0;
        for (int i = 0; i < NTHREADS; i++) begin
            if (w_gidx == c_TW'(i)) begin
                w_sel_pc = FetchPC[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Grant is gated by reset so every output reads zero while reset is held.
    always_comb begin
        w_next_state    = r_state;
        FetchGrant      = '0;
        InstValid       = '0;
        Enable          = 1'b0;
        CacheIndexRead  = '0;
        WriteInst       = 1'b0;
        CacheIndexWrite = '0;
        InstData        = '0;
        MemReq          = 1'b0;
        MemAddr         = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found && nReset) begin
                    FetchGrant   = c_ONE << w_gidx;
                    w_next_state = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (w_hit) begin
                    Enable         = 1'b1;
                    CacheIndexRead = w_idx;
                    w_next_state   = S_RESP;
                end else begin
                    w_next_state   = S_MISS;
                end
            end
            S_RESP: begin
                InstValid    = c_ONE << r_thread;
                w_next_state = S_IDLE;
            end
            S_MISS: begin
                MemReq  = 1'b1;
                MemAddr = {r_pc[31:2], 2'b00};
                if (MemAck) begin
                    w_next_state = S_FILL;
                end
            end
            S_FILL: begin
                WriteInst       = 1'b1;
                CacheIndexWrite = w_idx;
                InstData        = r_data;
                w_next_state    = S_LOOKUP;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_thread <= '0;
            r_last   <= c_TW'(NTHREADS - 1);
            r_pc     <= '0;
            r_data   <= '0;
        end else begin
            if ((r_state == S_IDLE) && w_found) begin
                r_thread <= w_gidx;
                r_last   <= w_gidx;
                r_pc     <= w_sel_pc;
            end
            if ((r_state == S_MISS) && MemAck) begin
                r_data <= MemData;
            end
        end
    end

    // Flush takes priority over the fill's valid set, but the tag still updates.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_valid <= '0;
            for (int i = 0; i < LINES; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            if (r_state == S_FILL) begin
                r_tag[w_idx] <= w_tag;
            end
            if (Flush) begin
                r_valid <= '0;
            end else if (r_state == S_FILL) begin
                r_valid[w_idx] <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_fetch_ctrl
// Description : Directed, table-driven self-checking bench for icache_fetch_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_fetch_ctrl;

    localparam int NT = 4;

    logic              clk = 1'b0;
    logic              nReset = 1'b0;
    logic [NT-1:0]     FetchReq = '0;
    logic [32*NT-1:0]  FetchPC = '0;
    logic              Flush = 1'b0;
    logic [NT-1:0]     FetchGrant;
    logic [NT-1:0]     InstValid;
    logic              Enable;
    logic [6:0]        CacheIndexRead;
    logic              WriteInst;
    logic [6:0]        CacheIndexWrite;
    logic [31:0]       InstData;
    logic              MemReq;
    logic [31:0]       MemAddr;
    logic              MemAck = 1'b0;
    logic [31:0]       MemData = '0;
    logic              Busy;

    int n_checks = 0;
    int n_errors = 0;
    int cur_seq  = 0;

    icache_fetch_ctrl #(.NTHREADS(NT), .LINES(128)) dut (
        .clk             (clk),
        .nReset          (nReset),
        .FetchReq        (FetchReq),
        .FetchPC         (FetchPC),
        .Flush           (Flush),
        .FetchGrant      (FetchGrant),
        .InstValid       (InstValid),
        .Enable          (Enable),
        .CacheIndexRead  (CacheIndexRead),
        .WriteInst       (WriteInst),
        .CacheIndexWrite (CacheIndexWrite),
        .InstData        (InstData),
        .MemReq          (MemReq),
        .MemAddr         (MemAddr),
        .MemAck          (MemAck),
        .MemData         (MemData),
        .Busy            (Busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          thr;
        logic [31:0] pc;
        logic [31:0] mdata;
        bit          hit;
        int          lat;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (seq %0d): got %h, expected %h", name, cur_seq, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full access for one thread; starts and ends just after a rising edge.
    task automatic do_access(input int t, input logic [31:0] pc, input logic [31:0] mdata,
                             input bit hit, input int lat);
        logic [NT-1:0] oh;
        logic [6:0]    idx;
        oh     = '0;
        oh[t]  = 1'b1;
        idx    = pc[8:2];
        FetchPC[32*t +: 32] = pc;
        FetchReq = oh;
        @(negedge clk);
        chk("grant", 32'(FetchGrant), 32'(oh));
        chk("grant_busy", 32'(Busy), 32'd0);
        tick();
        FetchReq = '0;
        if (!hit) begin
            @(negedge clk);
            chk("miss_no_enable", 32'(Enable), 32'd0);
            chk("lookup_busy", 32'(Busy), 32'd1);
            tick();
            for (int w = 0; w < lat; w++) begin
                @(negedge clk);
                chk("memreq_wait", 32'(MemReq), 32'd1);
                chk("memaddr", MemAddr, {pc[31:2], 2'b00});
                tick();
            end
            MemAck  = 1'b1;
            MemData = mdata;
            @(negedge clk);
            chk("memreq_ack", 32'(MemReq), 32'd1);
            tick();
            MemAck  = 1'b0;
            MemData = '0;
            @(negedge clk);
            chk("fill_write", 32'(WriteInst), 32'd1);
            chk("fill_index", 32'(CacheIndexWrite), 32'(idx));
            chk("fill_data", InstData, mdata);
            chk("fill_no_enable", 32'(Enable), 32'd0);
            chk("fill_no_memreq", 32'(MemReq), 32'd0);
            tick();
        end
        @(negedge clk);
        chk("hit_enable", 32'(Enable), 32'd1);
        chk("hit_index", 32'(CacheIndexRead), 32'(idx));
        chk("hit_no_memreq", 32'(MemReq), 32'd0);
        chk("hit_no_write", 32'(WriteInst), 32'd0);
        tick();
        @(negedge clk);
        chk("instvalid", 32'(InstValid), 32'(oh));
        chk("resp_no_enable", 32'(Enable), 32'd0);
        tick();
        @(negedge clk);
        chk("idle_busy", 32'(Busy), 32'd0);
        chk("idle_instvalid", 32'(InstValid), 32'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NT-1:0] got [5];
        logic [NT-1:0] exp_oh;
        int            ng;
        int            cyc;
        logic          ack;

        vecs[0] = '{thr: 0, pc: 32'h0000_0104, mdata: 32'h0010_0093, hit: 1'b0, lat: 3};
        vecs[1] = '{thr: 0, pc: 32'h0000_0104, mdata: 32'h0,         hit: 1'b1, lat: 0};
        vecs[2] = '{thr: 0, pc: 32'h0000_0304, mdata: 32'hDEAD_BEEF, hit: 1'b0, lat: 1};
        vecs[3] = '{thr: 0, pc: 32'h0000_0104, mdata: 32'h0010_0093, hit: 1'b0, lat: 0};
        vecs[4] = '{thr: 1, pc: 32'h0000_0104, mdata: 32'h0,         hit: 1'b1, lat: 0};
        vecs[5] = '{thr: 2, pc: 32'h0000_0208, mdata: 32'h1234_5678, hit: 1'b0, lat: 2};
        vecs[6] = '{thr: 3, pc: 32'h0000_0208, mdata: 32'h0,         hit: 1'b1, lat: 0};
        vecs[7] = '{thr: 0, pc: 32'hFFFF_FFFC, mdata: 32'hCAFE_F00D, hit: 1'b0, lat: 1};
        vecs[8] = '{thr: 0, pc: 32'hFFFF_FFFC, mdata: 32'h0,         hit: 1'b1, lat: 0};

        // Reset held with requests and a stray MemAck present: all outputs must stay 0.
        cur_seq  = 100;
        FetchReq = '1;
        for (int t = 0; t < NT; t++) FetchPC[32*t +: 32] = 32'h0000_0104;
        MemAck   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 32'(FetchGrant), 32'd0);
        chk("rst_instvalid", 32'(InstValid), 32'd0);
        chk("rst_enable", 32'(Enable), 32'd0);
        chk("rst_write", 32'(WriteInst), 32'd0);
        chk("rst_memreq", 32'(MemReq), 32'd0);
        chk("rst_memaddr", MemAddr, 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        FetchReq = '0;
        tick();
        nReset = 1'b1;

        // MemAck while idle is ignored.
        cur_seq = 101;
        MemData = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("idle_ack_write", 32'(WriteInst), 32'd0);
        chk("idle_ack_busy", 32'(Busy), 32'd0);
        tick();
        MemAck  = 1'b0;
        MemData = '0;

        for (int i = 0; i < 9; i++) begin
            cur_seq = i;
            do_access(vecs[i].thr, vecs[i].pc, vecs[i].mdata, vecs[i].hit, vecs[i].lat);
        end

        // Arbitration from reset with every thread requesting continuously.
        cur_seq = 200;
        nReset  = 1'b0;
        #3;
        nReset  = 1'b1;
        tick();
        for (int t = 0; t < NT; t++) FetchPC[32*t +: 32] = 32'h0000_0104;
        FetchReq = '1;
        MemData  = 32'h0010_0093;
        ng  = 0;
        cyc = 0;
        while (ng < 5 && cyc < 200) begin
            @(negedge clk);
            if (FetchGrant != '0) begin
                got[ng] = FetchGrant;
                ng++;
            end
            ack = MemReq;
            tick();
            MemAck = ack;
            if (ng == 5) FetchReq = '0;
            cyc++;
        end
        FetchReq = '0;
        cyc = 0;
        while (Busy && cyc < 100) begin
            @(negedge clk);
            ack = MemReq;
            tick();
            MemAck = ack;
            cyc++;
        end
        MemAck = 1'b0;
        chk("arb_drain_busy", 32'(Busy), 32'd0);
        chk("arb_grant_count", 32'(ng), 32'd5);
        for (int i = 0; i < ng; i++) begin
            exp_oh = '0;
            exp_oh[i % NT] = 1'b1;
            chk("arb_order", 32'(got[i]), 32'(exp_oh));
        end

        // Flush coincident with FILL: write happens, replay misses and refetches.
        cur_seq = 300;
        FetchPC[64 +: 32] = 32'h0000_0400;
        FetchReq = 4'b0100;
        @(negedge clk);
        chk("fl_grant", 32'(FetchGrant), 32'h4);
        tick();
        FetchReq = '0;
        @(negedge clk);
        chk("fl_lookup_miss", 32'(Enable), 32'd0);
        tick();
        MemAck  = 1'b1;
        MemData = 32'hA5A5_0001;
        @(negedge clk);
        chk("fl_memreq1", 32'(MemReq), 32'd1);
        chk("fl_memaddr1", MemAddr, 32'h0000_0400);
        tick();
        MemAck = 1'b0;
        Flush  = 1'b1;
        @(negedge clk);
        chk("fl_fill_write", 32'(WriteInst), 32'd1);
        chk("fl_fill_data", InstData, 32'hA5A5_0001);
        chk("fl_fill_index", 32'(CacheIndexWrite), 32'h00);
        tick();
        Flush = 1'b0;
        @(negedge clk);
        chk("fl_replay_miss", 32'(Enable), 32'd0);
        chk("fl_replay_busy", 32'(Busy), 32'd1);
        tick();
        @(negedge clk);
        chk("fl_memreq2", 32'(MemReq), 32'd1);
        chk("fl_memaddr2", MemAddr, 32'h0000_0400);
        tick();
        MemAck  = 1'b1;
        MemData = 32'hA5A5_0002;
        @(negedge clk);
        chk("fl_memreq2_ack", 32'(MemReq), 32'd1);
        tick();
        MemAck  = 1'b0;
        MemData = '0;
        @(negedge clk);
        chk("fl_fill2_data", InstData, 32'hA5A5_0002);
        tick();
        @(negedge clk);
        chk("fl_replay2_hit", 32'(Enable), 32'd1);
        tick();
        @(negedge clk);
        chk("fl_instvalid", 32'(InstValid), 32'h4);
        tick();

        // Flush also dropped the previously valid 0x104 line.
        cur_seq = 301;
        do_access(0, 32'h0000_0104, 32'h0010_0093, 1'b0, 1);

        // Reset in the middle of a miss abandons the access.
        cur_seq = 400;
        FetchPC[31:0] = 32'hFFFF_FFFC;
        FetchReq = 4'b0001;
        @(negedge clk);
        chk("rm_grant", 32'(FetchGrant), 32'h1);
        tick();
        FetchReq = '0;
        tick();
        @(negedge clk);
        chk("rm_memreq_before", 32'(MemReq), 32'd1);
        nReset = 1'b0;
        #1;
        chk("rm_memreq_dropped", 32'(MemReq), 32'd0);
        chk("rm_busy_dropped", 32'(Busy), 32'd0);
        #2;
        nReset = 1'b1;
        tick();
        MemAck  = 1'b1;
        MemData = 32'hBAD0_0001;
        @(negedge clk);
        chk("rm_late_ack_write", 32'(WriteInst), 32'd0);
        chk("rm_late_ack_busy", 32'(Busy), 32'd0);
        tick();
        MemAck  = 1'b0;
        MemData = '0;
        @(negedge clk);
        chk("rm_no_instvalid", 32'(InstValid), 32'd0);
        tick();

        cur_seq = 401;
        do_access(0, 32'h0000_0104, 32'h0010_0093, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/icache_fetch_ctrl.md
ICACHE_FETCH_CTRL -- requirements
Module: icache_fetch_ctrl

Interface
REQ-001 Parameter NTHREADS, 4, number of hardware threads sharing the instruction cache.
REQ-002 Parameter LINES, 128, cache entries, one 32-bit word each; index = PC[8:2], tag = PC[31:9].
REQ-003 Ports:
- clk  in  1  system clock, all state on rising edge.
- nReset  in  1  asynchronous, active-low reset.
- FetchReq  in  NTHREADS  per-thread fetch request, level, held until FetchGrant.
- FetchPC  in  32*NTHREADS  thread t PC at bits [32t+31:32t].
- Flush  in  1  invalidate all entries.
- FetchGrant  out  NTHREADS  one-hot, one-cycle pulse: request accepted.
- InstValid  out  NTHREADS  one-hot, one-cycle pulse: cache Inst output is the granted thread's instruction.
- Enable  out  1  cache read enable.
- CacheIndexRead  out  7  cache read index.
- WriteInst  out  1  cache write strobe.
- CacheIndexWrite  out  7  cache write index.
- InstData  out  32  cache write data.
- MemReq  out  1  refill request to memory.
- MemAddr  out  32  refill word address, bits [1:0] = 0.
- MemAck  in  1  memory returns MemData this cycle.
- MemData  in  32  refill data.
- Busy  out  1  high in every state except IDLE.

Function
REQ-004 The block SHALL hold a tag array of LINES entries (23-bit tag + valid bit) in flops.
REQ-005 FSM states SHALL be IDLE, LOOKUP, RESP, MISS, FILL.
REQ-006 IDLE: if any FetchReq, SHALL grant one thread round-robin (search from last granted + 1, wrapping), pulse FetchGrant[t] combinationally, latch t and FetchPC[t], go LOOKUP; else stay.
REQ-007 LOOKUP: valid[index] && tag match SHALL be hit: Enable=1, CacheIndexRead=index, go RESP; otherwise go MISS with no Enable.
REQ-008 RESP: InstValid[t]=1 for one cycle, go IDLE; hit latency = 2 cycles from grant cycle to InstValid cycle.
REQ-009 MISS: MemReq=1, MemAddr={PC[31:2],2'b00} held stable until MemAck; on MemAck SHALL capture MemData, go FILL.
REQ-010 FILL: WriteInst=1, CacheIndexWrite=index, InstData=captured word, tag[index]=PC tag, valid[index]=1, go LOOKUP (replay; hits unless flushed).
REQ-011 MemAck outside MISS SHALL be ignored.
REQ-012 Flush SHALL clear all valid bits at the next edge in any state; if coincident with FILL, the data write occurs but valid stays 0 (flush wins), so the replay misses and refills.
REQ-013 Requests deasserted before grant SHALL be dropped; requests arriving outside IDLE wait; at most one access in flight.
REQ-014 Enable and WriteInst SHALL never both be high in the same cycle; all outputs not named active in a state SHALL be 0.
REQ-015 Round-robin pointer SHALL update only on grant; with a single requester it SHALL be granted every access.

Reset
REQ-016 nReset low SHALL asynchronously force state IDLE, all valid bits 0, round-robin pointer so thread 0 has first priority, captured PC/data 0, every output 0.
REQ-017 Reset mid-miss SHALL abandon the access: MemReq drops immediately, no InstValid, no cache write; a later MemAck is ignored.

Verification
REQ-018 Cold miss: thread 0 PC=0x0000_0104, MemAck after 3 cycles with 0x0010_0093 -> MemAddr=0x104, WriteInst index 0x41, replay hit, InstValid[0] one cycle after Enable.
REQ-019 Hit: repeat PC 0x104 -> FetchGrant cycle N, Enable/CacheIndexRead=0x41 cycle N+1, InstValid[0] cycle N+2, no MemReq.
REQ-020 Alias: PC 0x0000_0304 after 0x104 (same index 0x41, tag differs) -> miss, refill overwrites entry; PC 0x104 then misses again.
REQ-021 Arbitration: all four FetchReq held high -> grant order 0,1,2,3,0; thread 3 never starved.
REQ-022 Flush asserted in FILL cycle -> write occurs, replay misses, second MemReq to same address.
REQ-023 nReset pulse while MemReq high -> MemReq=0 same cycle, Busy=0, subsequent PC 0x104 misses.
